// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Constants and types shared by the BCD conversion blocks: the
//   binary-to-BCD display converter and the reverse converter
//   bcd2bin_seq.
//   Contents:
//     BCD_W      width of one BCD digit
//     BCD_MAX    largest legal digit value
//     DD_THRESH  digit value at or above which the dabble correction applies
//     DD_CORR    size of the dabble correction
//     state_t    sequencer states IDLE -> CONV -> DONE
//     nib_bad    flags a nibble that is not a legal BCD digit
`timescale 1ns/1ps

package bcd_pkg;

  localparam int         BCD_W     = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] DD_THRESH = 4'd8;
  localparam logic [3:0] DD_CORR   = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic logic nib_bad(input logic [3:0] nib);
    return nib > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_nib_sub3.sv
// bcd_nib_sub3
//   Correction step for one digit of reverse double dabble. A digit that is
//   8 or more after the right shift has absorbed a binary weight of 8 that
//   belongs to the lower digit as 5. Subtracting 3 undoes this. The
//   subtraction is 4 bits wide, and no borrow crosses into the next digit.
//   Ports:
//     nib_in   in   4   shifted digit
//     nib_out  out  4   corrected digit
`timescale 1ns/1ps

module bcd_nib_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nib_in,
  output logic [BCD_W-1:0] nib_out
);

  assign nib_out = (nib_in >= DD_THRESH) ? (nib_in - DD_CORR) : nib_in;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq
//   Sequential BCD-to-binary converter that uses reverse double dabble.
//   Each CONV cycle shifts {digit reg, bin reg} right by one bit. Every
//   shifted digit nibble that is 8 or more then loses 3. After 4*DIGITS
//   shifts, bin reg holds the binary value. One conversion runs per
//   transaction, and both sides use a valid/ready handshake.
//   Ports:
//     clk        in   1          clock, rising edge
//     rst_n      in   1          asynchronous active-low reset
//     in_valid   in   1          dec_in valid
//     in_ready   out  1          high only in IDLE
//     dec_in     in   4*DIGITS   packed BCD digits, ones digit in [3:0]
//     out_valid  out  1          bin_out/dig_err valid (DONE)
//     out_ready  in   1          consumer accepts the result
//     bin_out    out  BW         binary value, forced to 0 on a digit error
//     dig_err    out  1          an input nibble was greater than 9
`timescale 1ns/1ps

module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BW     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BCD_W*DIGITS-1:0] dec_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         bin_out,
  output logic                  dig_err
);

  localparam int            DW   = BCD_W * DIGITS;
  localparam int            CW   = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  // The output must be able to hold the largest decimal entry, 10**DIGITS-1.
  if (DIGITS < 1 || (2 ** BW) < (10 ** DIGITS)) begin : g_param_check
    $error("bcd2bin_seq: BW=%0d cannot hold %0d BCD digits", BW, DIGITS);
  end

  state_t          state, state_nxt;
  logic [DW-1:0]   dig_reg, bin_reg;
  logic [DW-1:0]   dig_shift, bin_shift, dig_corr;
  logic [CW-1:0]   cnt;
  logic            err;
  logic            err_in;
  logic [BW-1:0]   bin_res;

  // The digit LSB falls into the bin MSB. The digits are corrected after
  // the shift.
  assign {dig_shift, bin_shift} = {dig_reg, bin_reg} >> 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_sub3
    bcd_nib_sub3 u_sub3 (
      .nib_in  (dig_shift[i*BCD_W +: BCD_W]),
      .nib_out (dig_corr[i*BCD_W +: BCD_W])
    );
  end

  // Any illegal digit is flagged at load time. The conversion still runs
  // for the full length so that the latency stays fixed.
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nib_bad(dec_in[i*BCD_W +: BCD_W])) err_in = 1'b1;
    end
  end

  // The upper bits of the shift register are always zero for legal input,
  // and BW is sized to fit the result, so those bits are dropped.
  if (BW <= DW) begin : g_trunc
    logic unused_hi_bits;
    assign bin_res = bin_reg[BW-1:0];
    if (BW < DW) begin : g_hi
      assign unused_hi_bits = ^bin_reg[DW-1:BW];
    end else begin : g_nohi
      assign unused_hi_bits = 1'b0;
    end
  end else begin : g_ext
    assign bin_res = {{(BW-DW){1'b0}}, bin_reg};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. in_valid is only acted on in IDLE, and out_ready is
  // only acted on in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = CONV;
      CONV:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. dec_in is loaded on the accept edge and then shifted once per
  // CONV cycle. The registers hold their values through DONE, so the
  // outputs stay stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dig_reg <= dec_in;
            bin_reg <= '0;
            cnt     <= '0;
            err     <= err_in;
          end
        end
        CONV: begin
          dig_reg <= dig_corr;
          bin_reg <= bin_shift;
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The handshake outputs are decoded only from the state register. No
  // input feeds them through combinational logic.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bin_out   = (state == DONE && !err) ? bin_res : '0;
  assign dig_err   = (state == DONE) ? err : 1'b0;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq
//   Directed bench for bcd2bin_seq with DIGITS=3 and BW=10. It checks the
//   reset state, the conversion results, the 12-clock latency, in_ready
//   behaviour, the output hold under backpressure, the mid-conversion reset
//   and a short random sweep that is checked against a decimal model.
`timescale 1ns/1ps

module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] dec_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [9:0]  bin_out;
  logic        dig_err;

  int checks = 0;
  int failures = 0;

  bcd2bin_seq #(.DIGITS(3), .BW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec_in    (dec_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .dig_err   (dig_err)
  );

  always #5 clk = ~clk;

  // Reference decimal value of a BCD word.
  function automatic int dec_model(input logic [11:0] d);
    return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents d until the DUT accepts it, then waits for out_valid while
  // recording the latency and whether in_ready rose during the conversion.
  task automatic applyStimulus(input logic [11:0] d, output int lat, output bit rdy_seen);
    int n;
    n = 0;
    in_valid = 1'b1;
    dec_in   = d;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    dec_in   = 12'hFAF;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input int lat, input bit rdy_seen,
                             input int exp_bin, input bit exp_err);
    chk({tag, "_latency"},    lat, 12);
    chk({tag, "_out_valid"},  out_valid, 1);
    chk({tag, "_bin_out"},    bin_out, exp_bin);
    chk({tag, "_dig_err"},    dig_err, exp_err);
    chk({tag, "_rdy_conv"},   rdy_seen, 0);
    chk({tag, "_rdy_done"},   in_ready, 0);
  endtask

  // Holds out_ready low for the given number of cycles, then completes the
  // output handshake and checks the return to IDLE.
  task automatic drain(input string tag, input int hold);
    out_ready = 1'b0;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"},   in_ready, 1);
  endtask

  initial begin
    int lat;
    bit rdy_seen;
    logic [11:0] d;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin_out",   bin_out, 0);
    chk("rst_dig_err",   dig_err, 0);
    rst_n = 1'b1;
    tick();

    // Mid-range value.
    applyStimulus(12'h255, lat, rdy_seen);
    checkOutput("t1_255", lat, rdy_seen, 255, 1'b0);
    drain("t1", 0);

    // Maximum value, then zero back-to-back.
    applyStimulus(12'h999, lat, rdy_seen);
    checkOutput("t2_999", lat, rdy_seen, 999, 1'b0);
    drain("t2a", 0);
    applyStimulus(12'h000, lat, rdy_seen);
    checkOutput("t2_000", lat, rdy_seen, 0, 1'b0);
    drain("t2b", 0);

    // Illegal tens digit.
    applyStimulus(12'h1A3, lat, rdy_seen);
    checkOutput("t3_1A3", lat, rdy_seen, 0, 1'b1);
    drain("t3", 0);

    // Backpressure: the result must hold for 5 stalled cycles.
    applyStimulus(12'h042, lat, rdy_seen);
    checkOutput("t4_042", lat, rdy_seen, 42, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_bin",   bin_out, 42);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_rdy",   in_ready, 0);
    end
    drain("t4", 0);

    // Reset during CONV at cnt=5 discards the conversion.
    in_valid = 1'b1;
    dec_in   = 12'h321;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t5_pre_rdy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy",   in_ready, 1);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_bin",   bin_out, 0);
    #2;
    rst_n = 1'b1;
    repeat (14) begin
      tick();
      chk("t5_no_stale_valid", out_valid, 0);
    end
    applyStimulus(12'h100, lat, rdy_seen);
    checkOutput("t5_100", lat, rdy_seen, 100, 1'b0);
    drain("t5", 0);

    // Short random sweep with random gaps on both sides.
    for (int k = 0; k < 8; k++) begin
      d[11:8] = 4'($urandom_range(0, 9));
      d[7:4]  = 4'($urandom_range(0, 9));
      d[3:0]  = 4'($urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(d, lat, rdy_seen);
      checkOutput("t6_rand", lat, rdy_seen, dec_model(d), 1'b0);
      drain("t6", $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
